// File: rtl/alu_op_issuer.sv
// Initiator for the microcoded mult/div/sqrt engine: accepts one request, pulses start,
// waits out the ROM latency, captures the result on ctrl_stop and aborts a hung engine.
module alu_op_issuer #(
   parameter int WORD_LENGHT    = 4,
   parameter int ROM_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 2*WORD_LENGHT+16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_opc,
   input  logic [WORD_LENGHT-1:0]   req_op_a,
   input  logic [WORD_LENGHT-1:0]   req_op_b,
   output logic [WORD_LENGHT-1:0]   op_a,
   output logic [WORD_LENGHT-1:0]   op_b,
   output logic                     start,
   output logic [1:0]               opc_code,
   output logic                     sync_rst,
   input  logic                     eng_stop,
   input  logic [2*WORD_LENGHT-1:0] eng_result,
   input  logic [WORD_LENGHT-1:0]   eng_remainder,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2*WORD_LENGHT-1:0] rsp_result,
   output logic [WORD_LENGHT-1:0]   rsp_remainder,
   output logic [1:0]               rsp_error,
   output logic                     busy
);

   localparam int W  = WORD_LENGHT;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // The timer holds k-1 in the k-th cycle after the start cycle.
   localparam logic [TW-1:0] BLIND_LAST   = TW'(ROM_LATENCY - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_MAX    = TW'(TIMEOUT_CYCLES);

   localparam logic [1:0] OPC_ILLEGAL = 2'b11;
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_BLIND     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ABORT     = 3'd4,
      ST_RESP      = 3'd5
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic [TW-1:0]   timer_r;
   logic [TW-1:0]   timer_nx_s;
   logic [TW-1:0]   timer_inc_s;
   logic            load_op_s;
   logic            load_rsp_s;
   logic [2*W-1:0]  rsp_result_nx_s;
   logic [W-1:0]    rsp_remainder_nx_s;
   logic [1:0]      rsp_error_nx_s;

   // Next-state, timer and response-load decode.
   always_comb begin
      state_nx_s         = state_r;
      timer_nx_s         = timer_r;
      load_op_s          = 1'b0;
      load_rsp_s         = 1'b0;
      rsp_result_nx_s    = '0;
      rsp_remainder_nx_s = '0;
      rsp_error_nx_s     = ERR_OK;
      timer_inc_s        = (timer_r == TIMER_MAX) ? timer_r : timer_r + TW'(1);

      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               load_op_s  = 1'b1;
               load_rsp_s = 1'b1;
               if (req_opc == OPC_ILLEGAL) begin
                  rsp_error_nx_s = ERR_ILLEGAL;
                  state_nx_s     = ST_RESP;
               end else begin
                  rsp_error_nx_s = ERR_OK;
                  state_nx_s     = ST_ISSUE;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            timer_nx_s = '0;
            if (ROM_LATENCY > 0) begin
               state_nx_s = ST_BLIND;
            end else begin
               state_nx_s = ST_WAIT_DONE;
            end
         end
         ST_BLIND: begin
            // ctrl_stop still shows the previous microprogram here.
            timer_nx_s = timer_inc_s;
            if (timer_r >= BLIND_LAST) begin
               state_nx_s = ST_WAIT_DONE;
            end else begin
               state_nx_s = ST_BLIND;
            end
         end
         ST_WAIT_DONE: begin
            timer_nx_s = timer_inc_s;
            if (eng_stop) begin
               load_rsp_s         = 1'b1;
               rsp_result_nx_s    = eng_result;
               rsp_remainder_nx_s = eng_remainder;
               rsp_error_nx_s     = ERR_OK;
               state_nx_s         = ST_RESP;
            end else if (timer_r >= TIMEOUT_LAST) begin
               load_rsp_s     = 1'b1;
               rsp_error_nx_s = ERR_TIMEOUT;
               state_nx_s     = ST_ABORT;
            end else begin
               state_nx_s = ST_WAIT_DONE;
            end
         end
         ST_ABORT: begin
            state_nx_s = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RESP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, handshake flags and operand/response registers; flags decode the next state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         timer_r       <= '0;
         req_ready     <= 1'b1;
         busy          <= 1'b0;
         start         <= 1'b0;
         sync_rst      <= 1'b0;
         rsp_valid     <= 1'b0;
         opc_code      <= 2'b11;
         op_a          <= '0;
         op_b          <= '0;
         rsp_result    <= '0;
         rsp_remainder <= '0;
         rsp_error     <= ERR_OK;
      end else begin
         state_r   <= state_nx_s;
         timer_r   <= timer_nx_s;
         req_ready <= (state_nx_s == ST_IDLE);
         busy      <= (state_nx_s != ST_IDLE);
         start     <= (state_nx_s == ST_ISSUE) || (state_nx_s == ST_ABORT);
         sync_rst  <= (state_nx_s == ST_ABORT);
         rsp_valid <= (state_nx_s == ST_RESP);
         if (load_op_s) begin
            op_a     <= req_op_a;
            op_b     <= req_op_b;
            opc_code <= req_opc;
         end
         if (load_rsp_s) begin
            rsp_result    <= rsp_result_nx_s;
            rsp_remainder <= rsp_remainder_nx_s;
            rsp_error     <= rsp_error_nx_s;
         end
      end
   end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer with a cycle-driven engine model
// (stale ctrl_stop during the ROM latency, programmable completion cycle).
module tb_alu_op_issuer;

   localparam int W    = 4;
   localparam int ROM  = 2;
   localparam int TO   = 2*W+16;
   localparam int KMAX = 60;

   localparam logic [5*W+8:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, {(5*W){1'b0}}, 2'b00};

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [1:0]     req_opc;
   logic [W-1:0]   req_op_a;
   logic [W-1:0]   req_op_b;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           start;
   logic [1:0]     opc_code;
   logic           sync_rst;
   logic           eng_stop;
   logic [2*W-1:0] eng_result;
   logic [W-1:0]   eng_remainder;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [2*W-1:0] rsp_result;
   logic [W-1:0]   rsp_remainder;
   logic [1:0]     rsp_error;
   logic           busy;

   int n_vec = 0;
   int n_mis = 0;
   logic [3*W+1:0] exp_q[$];

   int obs_start, obs_abort, obs_abort_k, obs_rsp_k;
   bit obs_sync_bad, obs_hold_bad;

   always #5 clk = ~clk;

   alu_op_issuer #(.WORD_LENGHT(W), .ROM_LATENCY(ROM), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
      .req_op_a(req_op_a), .req_op_b(req_op_b),
      .op_a(op_a), .op_b(op_b), .start(start), .opc_code(opc_code), .sync_rst(sync_rst),
      .eng_stop(eng_stop), .eng_result(eng_result), .eng_remainder(eng_remainder),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_remainder(rsp_remainder), .rsp_error(rsp_error), .busy(busy)
   );

   function automatic logic [3*W-1:0] engine_calc(input logic [1:0] opc, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
      int ia, ib, s;
      logic [2*W-1:0] r;
      logic [W-1:0]   m;
      ia = int'(a);
      ib = int'(b);
      s  = 0;
      r  = '0;
      m  = '0;
      case (opc)
         2'b00: begin
            if (ib != 0) begin
               r = (2*W)'(ia / ib);
               m = W'(ia % ib);
            end else begin
               r = '1;
               m = a;
            end
         end
         2'b01: begin
            while ((s + 1) * (s + 1) <= ia) s++;
            r = (2*W)'(s);
            m = W'(ia - s * s);
         end
         2'b10: r = (2*W)'(ia * ib);
         default: begin
            r = '0;
            m = '0;
         end
      endcase
      return {r, m};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one request; engine raises ctrl_stop with the true result in cycle d after start.
   task automatic drive_op(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int d);
      logic [3*W-1:0] eng;
      logic [3*W+1:0] exp_v;
      logic [3*W+1:0] got_v;
      int k;
      eng = engine_calc(opc, a, b);
      if (opc == 2'b11) exp_v = {{(3*W){1'b0}}, 2'b01};
      else if (d > TO)  exp_v = {{(3*W){1'b0}}, 2'b10};
      else              exp_v = {eng, 2'b00};
      exp_q.push_back(exp_v);
      obs_start = 0; obs_abort = 0; obs_abort_k = -1; obs_rsp_k = -1;
      obs_sync_bad = 1'b0; obs_hold_bad = 1'b0;
      req_valid = 1'b1; req_opc = opc; req_op_a = a; req_op_b = b;
      step();
      req_valid = 1'b0; req_op_a = ~a; req_op_b = ~b;
      k = 0;
      while (rsp_valid !== 1'b1 && k < KMAX) begin
         if (start === 1'b1 && sync_rst === 1'b0) obs_start++;
         if (start === 1'b1 && sync_rst === 1'b1) begin
            obs_abort++;
            obs_abort_k = k;
         end
         if (sync_rst === 1'b1 && start !== 1'b1) obs_sync_bad = 1'b1;
         if (opc_code !== opc || op_a !== a || op_b !== b || busy !== 1'b1 || req_ready !== 1'b0)
            obs_hold_bad = 1'b1;
         eng_stop      = (k <= ROM) || (k >= d);
         eng_result    = (k >= d) ? eng[3*W-1:W] : ~eng[3*W-1:W];
         eng_remainder = (k >= d) ? eng[W-1:0]   : ~eng[W-1:0];
         step();
         k++;
      end
      eng_stop = 1'b1; eng_result = ~eng[3*W-1:W]; eng_remainder = ~eng[W-1:0];
      exp_v = exp_q.pop_front();
      n_vec++;
      if (rsp_valid !== 1'b1) begin
         n_mis++;
         $display("FAIL rsp_wait: rsp_valid still %b after %0d cycles, required 1", rsp_valid, KMAX);
      end else begin
         obs_rsp_k = k;
         got_v = {rsp_result, rsp_remainder, rsp_error};
         if (got_v !== exp_v) begin
            n_mis++;
            $display("FAIL scoreboard opc=%b a=%0d b=%0d: got res=%0d rem=%0d err=%b, required res=%0d rem=%0d err=%b",
                     opc, a, b, got_v[3*W+1:W+2], got_v[W+1:2], got_v[1:0],
                     exp_v[3*W+1:W+2], exp_v[W+1:2], exp_v[1:0]);
         end
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({req_ready, start, sync_rst, rsp_valid, busy, opc_code, op_a, op_b, rsp_result,
           rsp_remainder, rsp_error} !== RST_VEC) begin
         n_mis++;
         $display("FAIL reset_state: got %h required %h", {req_ready, start, sync_rst, rsp_valid, busy,
                  opc_code, op_a, op_b, rsp_result, rsp_remainder, rsp_error}, RST_VEC);
      end
      rst = 1'b1;
      step();
      n_vec++;
      if ({req_ready, start, busy, rsp_valid} !== 4'b1000) begin
         n_mis++;
         $display("FAIL idle_after_reset: got %b required 1000", {req_ready, start, busy, rsp_valid});
      end
   endtask

   task automatic test_mult();
      drive_op(2'b10, 4'd13, 4'd11, 12);
      n_vec++;
      if (obs_start != 1 || obs_abort != 0 || obs_sync_bad || obs_hold_bad) begin
         n_mis++;
         $display("FAIL mult_handshake: starts=%0d aborts=%0d sync_bad=%0d hold_bad=%0d required 1 0 0 0",
                  obs_start, obs_abort, obs_sync_bad, obs_hold_bad);
      end
      n_vec++;
      if (obs_rsp_k != 13 || rsp_result !== 8'd143 || rsp_error !== 2'b00) begin
         n_mis++;
         $display("FAIL mult_result: cycle=%0d res=%0d err=%b required 13 143 00", obs_rsp_k, rsp_result, rsp_error);
      end
      release_rsp();
      n_vec++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         n_mis++;
         $display("FAIL mult_release: got %b required 010", {rsp_valid, req_ready, busy});
      end
   endtask

   task automatic test_div_hold();
      drive_op(2'b00, 4'd14, 4'd3, 7);
      n_vec++;
      if (obs_rsp_k != 8 || rsp_result !== 8'd4 || rsp_remainder !== 4'd2) begin
         n_mis++;
         $display("FAIL div_result: cycle=%0d res=%0d rem=%0d required 8 4 2", obs_rsp_k, rsp_result, rsp_remainder);
      end
      for (int h = 0; h < 5; h++) begin
         eng_stop = 1'(h % 2);
         eng_result = 8'(h * 37);
         step();
         n_vec++;
         if ({rsp_valid, rsp_result, rsp_remainder, rsp_error, req_ready, busy} !== {1'b1, 8'd4, 4'd2, 2'b00, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL div_hold_%0d: got %h required %h", h,
                     {rsp_valid, rsp_result, rsp_remainder, rsp_error, req_ready, busy},
                     {1'b1, 8'd4, 4'd2, 2'b00, 1'b0, 1'b1});
         end
      end
      release_rsp();
      n_vec++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         n_mis++;
         $display("FAIL div_release: got %b required 010", {rsp_valid, req_ready, busy});
      end
   endtask

   task automatic test_illegal();
      drive_op(2'b11, 4'd5, 4'd6, 3);
      n_vec++;
      if (obs_rsp_k != 0 || start !== 1'b0 || rsp_error !== 2'b01 || rsp_result !== 8'd0) begin
         n_mis++;
         $display("FAIL illegal_opc: cycle=%0d start=%b err=%b res=%0d required 0 0 01 0",
                  obs_rsp_k, start, rsp_error, rsp_result);
      end
      release_rsp();
      n_vec++;
      if ({start, rsp_valid, req_ready} !== 3'b001) begin
         n_mis++;
         $display("FAIL illegal_release: got %b required 001", {start, rsp_valid, req_ready});
      end
   endtask

   task automatic test_timeout();
      drive_op(2'b01, 4'd9, 4'd0, 1000);
      n_vec++;
      if (obs_start != 1 || obs_abort != 1 || obs_abort_k != TO + 1 || obs_sync_bad) begin
         n_mis++;
         $display("FAIL timeout_abort: starts=%0d aborts=%0d abort_cycle=%0d sync_bad=%0d required 1 1 %0d 0",
                  obs_start, obs_abort, obs_abort_k, obs_sync_bad, TO + 1);
      end
      n_vec++;
      if (obs_rsp_k != TO + 2 || rsp_error !== 2'b10) begin
         n_mis++;
         $display("FAIL timeout_rsp: cycle=%0d err=%b required %0d 10", obs_rsp_k, rsp_error, TO + 2);
      end
      release_rsp();
   endtask

   task automatic test_timeout_edge();
      drive_op(2'b10, 4'd7, 4'd9, TO);
      n_vec++;
      if (obs_abort != 0 || obs_rsp_k != TO + 1 || rsp_error !== 2'b00) begin
         n_mis++;
         $display("FAIL last_cycle_done: aborts=%0d cycle=%0d err=%b required 0 %0d 00",
                  obs_abort, obs_rsp_k, rsp_error, TO + 1);
      end
      release_rsp();
      drive_op(2'b10, 4'd7, 4'd9, TO + 1);
      n_vec++;
      if (obs_abort != 1 || obs_abort_k != TO + 1 || rsp_error !== 2'b10) begin
         n_mis++;
         $display("FAIL one_cycle_late: aborts=%0d abort_cycle=%0d err=%b required 1 %0d 10",
                  obs_abort, obs_abort_k, rsp_error, TO + 1);
      end
      release_rsp();
   endtask

   task automatic test_blind_stale();
      drive_op(2'b01, 4'd15, 4'd0, ROM + 1);
      n_vec++;
      if (obs_rsp_k != ROM + 2 || rsp_result !== 8'd3 || rsp_remainder !== 4'd6) begin
         n_mis++;
         $display("FAIL best_latency_sqrt: cycle=%0d res=%0d rem=%0d required %0d 3 6",
                  obs_rsp_k, rsp_result, rsp_remainder, ROM + 2);
      end
      release_rsp();
      drive_op(2'b00, 4'd11, 4'd4, 6);
      n_vec++;
      if (obs_rsp_k != 7 || obs_start != 1) begin
         n_mis++;
         $display("FAIL stale_stop: cycle=%0d starts=%0d required 7 1", obs_rsp_k, obs_start);
      end
      release_rsp();
   endtask

   task automatic test_back_to_back();
      drive_op(2'b10, 4'd15, 4'd15, 5);
      req_valid = 1'b1; req_opc = 2'b00; req_op_a = 4'd9; req_op_b = 4'd2;
      for (int h = 0; h < 2; h++) begin
         step();
         n_vec++;
         if ({req_ready, start, rsp_valid, rsp_result} !== {1'b0, 1'b0, 1'b1, 8'd225}) begin
            n_mis++;
            $display("FAIL b2b_no_accept_%0d: got %h required %h", h,
                     {req_ready, start, rsp_valid, rsp_result}, {1'b0, 1'b0, 1'b1, 8'd225});
         end
      end
      release_rsp();
      drive_op(2'b00, 4'd9, 4'd2, 4);
      n_vec++;
      if (obs_start != 1 || obs_rsp_k != 5 || rsp_result !== 8'd4 || rsp_remainder !== 4'd1) begin
         n_mis++;
         $display("FAIL b2b_second: starts=%0d cycle=%0d res=%0d rem=%0d required 1 5 4 1",
                  obs_start, obs_rsp_k, rsp_result, rsp_remainder);
      end
      release_rsp();
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_opc = 2'b10; req_op_a = 4'd3; req_op_b = 4'd5;
      step();
      req_valid = 1'b0;
      eng_stop = 1'b0;
      repeat (4) step();
      rst = 1'b0;
      step();
      n_vec++;
      if ({req_ready, start, sync_rst, rsp_valid, busy, opc_code, op_a, op_b, rsp_result,
           rsp_remainder, rsp_error} !== RST_VEC) begin
         n_mis++;
         $display("FAIL mid_op_reset: got %h required %h", {req_ready, start, sync_rst, rsp_valid, busy,
                  opc_code, op_a, op_b, rsp_result, rsp_remainder, rsp_error}, RST_VEC);
      end
      rst = 1'b1;
      eng_stop = 1'b1;
      repeat (2) step();
      n_vec++;
      if ({req_ready, start, sync_rst, rsp_valid, busy, opc_code, op_a, op_b, rsp_result,
           rsp_remainder, rsp_error} !== RST_VEC) begin
         n_mis++;
         $display("FAIL post_reset_idle: got %h required %h", {req_ready, start, sync_rst, rsp_valid, busy,
                  opc_code, op_a, op_b, rsp_result, rsp_remainder, rsp_error}, RST_VEC);
      end
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_opc = 2'b00; req_op_a = '0; req_op_b = '0;
      eng_stop = 1'b1; eng_result = '0; eng_remainder = '0; rsp_ready = 1'b0;
      test_reset();
      test_mult();
      test_div_hold();
      test_illegal();
      test_timeout();
      test_timeout_edge();
      test_blind_stale();
      test_back_to_back();
      test_reset_mid();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_mis++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
